// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data memory controller.
package dmem_pkg;

   // CLEAR: zeroing sweep in progress; RUN: servicing requests.
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int DMEM_DEFAULT_DATA_WIDTH = 16;
   localparam int DMEM_DEFAULT_DEPTH      = 8192;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with byte-lane write mask and registered read.
// Holds no reset: contents survive reset unless the controller sweeps them.
module dmem_array #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8192,
   localparam int IDX_W     = $clog2(DEPTH),
   localparam int LANES     = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [LANES-1:0]      be,
   input  logic [IDX_W-1:0]      idx,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Masked lane write and read-first registered read on the same index.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < LANES; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: valid/ready request port, range check, registered
// read/error response, and an optional zeroing sweep after reset.
// Optional feature: define DMEM_CLEAR_EN to build the CLEAR state and sweep
// counter; otherwise reset goes straight to RUN and memory is left untouched.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = DMEM_DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DMEM_DEFAULT_DEPTH,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_i,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   output logic                    ready_o,
   output logic                    rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    err_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int LANES = DATA_WIDTH / 8;
   // One extra bit so DEPTH itself is representable for the range compare.
   localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

   state_t                state;
   state_t                next_state;
   logic                  ready_q;
   logic                  rvalid_p1;
   logic                  err_p1;
   logic                  rd_ok_p1;
   logic                  accept;
   logic                  in_range;
   logic                  arr_we;
   logic [LANES-1:0]      arr_be;
   logic [IDX_W-1:0]      arr_idx;
   logic [DATA_WIDTH-1:0] arr_wdata;
   logic [DATA_WIDTH-1:0] arr_rdata;

   assign accept   = req_i && ready_q;
   // Full-width compare: aliasing upper bits never reach the array.
   assign in_range = {1'b0, addr_i} < DEPTH_X;

`ifdef DMEM_CLEAR_EN
   localparam state_t RESET_STATE = CLEAR;
   logic [IDX_W-1:0] ptr;

   // Sweep pointer: restarts at 0 on every reset, advances once per CLEAR cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) ptr <= '0;
      else if (state == CLEAR) ptr <= ptr + IDX_W'(1);
   end

   // Next state: leave CLEAR right after the last word is zeroed.
   always_comb begin
      next_state = state;
      if (state == CLEAR && ptr == IDX_W'(DEPTH - 1)) next_state = RUN;
   end
`else
   localparam state_t RESET_STATE = RUN;

   // Next state: no sweep, RUN is held indefinitely.
   always_comb begin
      next_state = state;
   end
`endif

   // State register; ready is registered so it is low throughout reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= RESET_STATE;
         ready_q <= 1'b0;
      end else begin
         state   <= next_state;
         ready_q <= (next_state == RUN);
      end
   end

   // Array port mux: requests in RUN, all-lane zero writes during the sweep.
   always_comb begin
      arr_we    = 1'b0;
      arr_be    = be_i;
      arr_idx   = addr_i[IDX_W-1:0];
      arr_wdata = wdata_i;
      if (rst_n) arr_we = accept && we_i && in_range;
`ifdef DMEM_CLEAR_EN
      if (state == CLEAR) begin
         arr_we    = rst_n;
         arr_be    = '1;
         arr_idx   = ptr;
         arr_wdata = '0;
      end
`endif
   end

   dmem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .be    (arr_be),
      .idx   (arr_idx),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   // Response flags for the request accepted at this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_p1 <= 1'b0;
         err_p1    <= 1'b0;
         rd_ok_p1  <= 1'b0;
      end else begin
         rvalid_p1 <= accept && !we_i;
         err_p1    <= accept && !in_range;
         rd_ok_p1  <= accept && !we_i && in_range;
      end
   end

   assign ready_o  = ready_q;
   assign rvalid_o = rvalid_p1;
   assign err_o    = err_p1;
   // Array output is only exposed for a successful read; zero otherwise.
   assign rdata_o  = rd_ok_p1 ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (DATA_WIDTH=16, DEPTH=16, ADDR_WIDTH=8).
// Works with or without DMEM_CLEAR_EN defined.
module tb_dmem_ctrl;

   localparam int DW  = 16;
   localparam int DEP = 16;
   localparam int AW  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [1:0]    be;
   logic          ready;
   logic          rvalid;
   logic          err;
   logic [DW-1:0] rdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference memory: word contents plus which byte lanes hold known data.
   logic [15:0] mem_m   [DEP];
   logic [1:0]  known_m [DEP];

   typedef struct {
      logic        rq;
      logic        w;
      logic [7:0]  a;
      logic [15:0] wd;
      logic [1:0]  b;
      logic        rv;
      logic        er;
      logic [15:0] rd;
   } vec_t;

   vec_t tbl [16];

   always #5 clk = ~clk;

   dmem_ctrl #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEP),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req),
      .we_i     (we),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .be_i     (be),
      .ready_o  (ready),
      .rvalid_o (rvalid),
      .rdata_o  (rdata),
      .err_o    (err)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear;
      for (int i = 0; i < DEP; i++) begin
         mem_m[i]   = 16'h0;
         known_m[i] = 2'b11;
      end
   endtask

   // Predict the response of one request from the model, update the model,
   // then present the request across one clock edge.
   task automatic cycle(input logic rq, input logic w, input logic [AW-1:0] a,
                        input logic [15:0] wd, input logic [1:0] b,
                        output logic e_rv, output logic e_err,
                        output logic [15:0] e_rd, output logic [15:0] e_mask);
      int ai;
      ai     = int'(a);
      e_rv   = 1'b0;
      e_err  = 1'b0;
      e_rd   = 16'h0;
      e_mask = 16'hFFFF;
      if (rq) begin
         if (ai < DEP) begin
            if (w) begin
               for (int l = 0; l < 2; l++) begin
                  if (b[l]) begin
                     mem_m[ai][8*l +: 8] = wd[8*l +: 8];
                     known_m[ai][l]      = 1'b1;
                  end
               end
            end else begin
               e_rv   = 1'b1;
               e_rd   = mem_m[ai];
               e_mask = {{8{known_m[ai][1]}}, {8{known_m[ai][0]}}};
            end
         end else begin
            e_err = 1'b1;
            e_rv  = !w;
         end
      end
      req   = rq;
      we    = w;
      addr  = a;
      wdata = wd;
      be    = b;
      step();
   endtask

   task automatic check_resp(input string tag, input logic e_rv, input logic e_err,
                             input logic [15:0] e_rd, input logic [15:0] e_mask);
      check({tag, ".rvalid"}, 32'(rvalid), 32'(e_rv));
      check({tag, ".err"}, 32'(err), 32'(e_err));
      check({tag, ".rdata"}, 32'(rdata & e_mask), 32'(e_rd & e_mask));
   endtask

   task automatic read_all_zero(input string tag);
      logic        e_rv, e_err;
      logic [15:0] e_rd, e_mask;
      for (int a = 0; a < DEP; a++) begin
         cycle(1'b1, 1'b0, AW'(a), 16'h0, 2'b00, e_rv, e_err, e_rd, e_mask);
         check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
         check({tag, ".rdata"}, 32'(rdata), 32'h0);
         check({tag, ".err"}, 32'(err), 32'd0);
      end
      req = 1'b0;
   endtask

   initial begin
      logic        e_rv, e_err;
      logic [15:0] e_rd, e_mask;

      for (int i = 0; i < DEP; i++) begin
         mem_m[i]   = 16'h0;
         known_m[i] = 2'b00;
      end

      tbl[0]  = '{1'b1, 1'b1, 8'h05, 16'hABCD, 2'b11, 1'b0, 1'b0, 16'h0000};
      tbl[1]  = '{1'b1, 1'b1, 8'h05, 16'h1200, 2'b10, 1'b0, 1'b0, 16'h0000};
      tbl[2]  = '{1'b1, 1'b0, 8'h05, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h12CD};
      tbl[3]  = '{1'b1, 1'b1, 8'h03, 16'h00AA, 2'b11, 1'b0, 1'b0, 16'h0000};
      tbl[4]  = '{1'b1, 1'b0, 8'h03, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h00AA};
      tbl[5]  = '{1'b1, 1'b1, 8'h15, 16'hFFFF, 2'b11, 1'b0, 1'b1, 16'h0000};
      tbl[6]  = '{1'b1, 1'b0, 8'h15, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h0000};
      tbl[7]  = '{1'b1, 1'b0, 8'h05, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h12CD};
      tbl[8]  = '{1'b0, 1'b0, 8'h05, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000};
      tbl[9]  = '{1'b1, 1'b1, 8'h05, 16'h7777, 2'b00, 1'b0, 1'b0, 16'h0000};
      tbl[10] = '{1'b1, 1'b0, 8'h05, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h12CD};
      tbl[11] = '{1'b1, 1'b1, 8'h0F, 16'hBEEF, 2'b11, 1'b0, 1'b0, 16'h0000};
      tbl[12] = '{1'b1, 1'b0, 8'h0F, 16'h0000, 2'b00, 1'b1, 1'b0, 16'hBEEF};
      tbl[13] = '{1'b1, 1'b1, 8'h10, 16'h5555, 2'b11, 1'b0, 1'b1, 16'h0000};
      tbl[14] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h0000};
      tbl[15] = '{1'b1, 1'b0, 8'h03, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h00AA};

      // Reset with a read request pending: reset wins, outputs stay zero.
      rst_n = 1'b0;
      req   = 1'b1;
      we    = 1'b0;
      addr  = 8'h05;
      wdata = 16'h0;
      be    = 2'b00;
      repeat (3) step();
      check("reset.ready", 32'(ready), 32'd0);
      check("reset.rvalid", 32'(rvalid), 32'd0);
      check("reset.err", 32'(err), 32'd0);
      check("reset.rdata", 32'(rdata), 32'h0);
      req   = 1'b0;
      rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
      for (int i = 1; i <= DEP; i++) begin
         step();
         check($sformatf("sweep.ready[%0d]", i), 32'(ready), 32'(i == DEP));
      end
      model_clear();
      read_all_zero("sweep.read");
`else
      step();
      check("release.ready", 32'(ready), 32'd1);
`endif

      // Directed vectors: byte lanes, back-to-back, range errors, idle, no-op.
      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].rq, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].b, e_rv, e_err, e_rd, e_mask);
         check($sformatf("tbl[%0d].ready", i), 32'(ready), 32'd1);
         check($sformatf("tbl[%0d].rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
         check($sformatf("tbl[%0d].err", i), 32'(err), 32'(tbl[i].er));
         check($sformatf("tbl[%0d].rdata", i), 32'(rdata), 32'(tbl[i].rd));
      end

      // Randomised traffic against the reference memory.
      for (int i = 0; i < 400; i++) begin
         logic          rq, w;
         logic [AW-1:0] a;
         rq = ($urandom_range(0, 3) != 0);
         w  = $urandom_range(0, 1) == 1;
         a  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 255))
                                           : AW'($urandom_range(0, DEP + 3));
         cycle(rq, w, a, 16'($urandom), 2'($urandom), e_rv, e_err, e_rd, e_mask);
         check_resp($sformatf("rand[%0d]", i), e_rv, e_err, e_rd, e_mask);
      end
      req = 1'b0;

`ifdef DMEM_CLEAR_EN
      // Reset partway through a sweep: the sweep restarts from word 0.
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         check($sformatf("mid.ready[%0d]", i), 32'(ready), 32'd0);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 1; i <= DEP; i++) begin
         step();
         check($sformatf("resweep.ready[%0d]", i), 32'(ready), 32'(i == DEP));
      end
      model_clear();
      read_all_zero("resweep.read");
`else
      // Reset keeps memory contents; ready returns on the first released edge.
      rst_n = 1'b0;
      req   = 1'b1;
      we    = 1'b0;
      addr  = 8'h05;
      step();
      check("rst2.ready", 32'(ready), 32'd0);
      check("rst2.rvalid", 32'(rvalid), 32'd0);
      check("rst2.rdata", 32'(rdata), 32'h0);
      req   = 1'b0;
      rst_n = 1'b1;
      step();
      check("rst2.release.ready", 32'(ready), 32'd1);
      cycle(1'b1, 1'b1, 8'h00, 16'h4321, 2'b11, e_rv, e_err, e_rd, e_mask);
      check_resp("rst2.wr0", e_rv, e_err, e_rd, e_mask);
      cycle(1'b1, 1'b0, 8'h00, 16'h0000, 2'b00, e_rv, e_err, e_rd, e_mask);
      check("rst2.rd0.rdata", 32'(rdata), 32'h4321);
      check_resp("rst2.rd0", e_rv, e_err, e_rd, e_mask);
      cycle(1'b1, 1'b0, 8'h05, 16'h0000, 2'b00, e_rv, e_err, e_rd, e_mask);
      check_resp("rst2.rd5", e_rv, e_err, e_rd, e_mask);
      req = 1'b0;
`endif

      // Idle cycle after traffic: all response outputs return to zero.
      cycle(1'b0, 1'b0, 8'h00, 16'h0, 2'b00, e_rv, e_err, e_rd, e_mask);
      check_resp("idle", e_rv, e_err, e_rd, e_mask);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
